// File: rtl/pwm_bank_if.sv
// Write port of pwm_bank: per-channel duty/ramp programming, always-ready.
interface pwm_bank_if #(
  parameter int unsigned CHW = 2,
  parameter int unsigned CW  = 11
);
  logic           wr_valid;
  logic           wr_ready;
  logic [CHW-1:0] wr_ch;
  logic           wr_mode;
  logic [CW-1:0]  wr_value;
  logic [CW-1:0]  wr_step;

  modport master (output wr_valid, wr_ch, wr_mode, wr_value, wr_step, input wr_ready);
  modport slave  (input wr_valid, wr_ch, wr_mode, wr_value, wr_step, output wr_ready);
endinterface

// File: rtl/pwm_bank.sv
// Multi-channel PWM with a shared period counter; duties change only at period
// boundaries, either jumping to the target or ramping toward it.
module pwm_bank #(
  parameter int unsigned NUM_CH       = 3,
  parameter int unsigned PWM_INTERVAL = 1200,
  parameter bit          ACTIVE_LOW   = 1'b1,
  parameter int unsigned CW           = $clog2(PWM_INTERVAL + 1),
  parameter int unsigned CHW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  pwm_bank_if.slave         wr,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] busy,
  output logic              period_start
);

  localparam int unsigned   CW1      = CW + 1;
  localparam logic [CW-1:0] MAX_DUTY = CW'(PWM_INTERVAL);
  localparam logic [CW-1:0] LAST_CNT = CW'(PWM_INTERVAL - 1);

  logic [CW-1:0]              cnt_q, cnt_d;
  logic [NUM_CH-1:0][CW-1:0]  duty_q, duty_d;
  logic [NUM_CH-1:0][CW-1:0]  target_q, target_d;
  logic [NUM_CH-1:0][CW-1:0]  step_q, step_d;
  logic [NUM_CH-1:0]          mode_q, mode_d;
  logic [NUM_CH-1:0]          pwm_out_q, pwm_out_d;
  logic [NUM_CH-1:0]          busy_q, busy_d;
  logic                       period_start_q, period_start_d;
  logic                       wr_ready_q, wr_ready_d;

  logic                       at_boundary;
  logic                       wr_fire;
  logic [CW-1:0]              wr_value_clamped;
  logic [CW1-1:0]             step_eff;
  logic [CW1-1:0]             up_sum;
  logic [CW1-1:0]             dn_gap;

  assign at_boundary      = (cnt_q == LAST_CNT);
  assign wr_fire          = wr.wr_valid && wr_ready_q;
  assign wr_value_clamped = (wr.wr_value > MAX_DUTY) ? MAX_DUTY : wr.wr_value;

  assign wr.wr_ready   = wr_ready_q;
  assign pwm_out       = pwm_out_q;
  assign busy          = busy_q;
  assign period_start  = period_start_q;

  // Free-running period counter
  always_comb begin
    cnt_d      = at_boundary ? '0 : cnt_q + CW'(1);
    wr_ready_d = 1'b1;
  end

  // Write capture; out-of-range channel indices match no channel and are dropped
  always_comb begin
    target_d = target_q;
    step_d   = step_q;
    mode_d   = mode_q;
    if (wr_fire) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (wr.wr_ch == CHW'(i)) begin
          target_d[i] = wr_value_clamped;
          step_d[i]   = wr.wr_step;
          mode_d[i]   = wr.wr_mode;
        end
      end
    end
  end

  // Boundary duty update; ramp math at CW+1 bits so neither direction can wrap
  always_comb begin
    duty_d   = duty_q;
    step_eff = '0;
    up_sum   = '0;
    dn_gap   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      step_eff = (step_q[i] == '0) ? CW1'(1) : {1'b0, step_q[i]};
      up_sum   = {1'b0, duty_q[i]} + step_eff;
      dn_gap   = {1'b0, duty_q[i]} - {1'b0, target_q[i]};
      if (at_boundary) begin
        if (!mode_q[i]) begin
          duty_d[i] = target_q[i];
        end else if (duty_q[i] < target_q[i]) begin
          duty_d[i] = (up_sum >= {1'b0, target_q[i]}) ? target_q[i] : up_sum[CW-1:0];
        end else if (duty_q[i] > target_q[i]) begin
          duty_d[i] = (dn_gap <= step_eff) ? target_q[i] : CW'({1'b0, duty_q[i]} - step_eff);
        end
      end
    end
  end

  // Output stage: one cycle behind the counter, so period_start marks cnt==0's output
  always_comb begin
    pwm_out_d      = '0;
    busy_d         = '0;
    period_start_d = (cnt_q == '0);
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pwm_out_d[i] = (cnt_q < duty_q[i]) ^ ACTIVE_LOW;
      busy_d[i]    = (duty_q[i] != target_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      duty_q         <= '0;
      target_q       <= '0;
      step_q         <= '0;
      mode_q         <= '0;
      pwm_out_q      <= {NUM_CH{ACTIVE_LOW}};
      busy_q         <= '0;
      period_start_q <= 1'b0;
      wr_ready_q     <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      duty_q         <= duty_d;
      target_q       <= target_d;
      step_q         <= step_d;
      mode_q         <= mode_d;
      pwm_out_q      <= pwm_out_d;
      busy_q         <= busy_d;
      period_start_q <= period_start_d;
      wr_ready_q     <= wr_ready_d;
    end
  end

endmodule
